mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbiter and sequencer for the shared data-memory/peripheral bus. It sits between the pipeline MEM stage and the DataMem/Peripheral decode, and shares that bus with a second master: the UART debug/loader port. It grants one master at a time, holds the grant until the slave answers with `bus_ready`, stalls the pipeline while a CPU access is outstanding, and prevents the debug port from starving under priority arbitration.

## Interface
- `MAX_WAIT`, 8: cycles a pending debug request may lose arbitration before it is forced to win.
- `TIMEOUT`, 64: cycles a granted transfer may wait for `bus_ready` before it is aborted (only with `MEM_ARB_TIMEOUT_EN`).
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `cpu_rd` in 1: MEM-stage read request (MemRd).
- `cpu_wr` in 1: MEM-stage write request (MemWr).
- `cpu_addr` in 32: MEM-stage address (ALUOut).
- `cpu_wdata` in 32: MEM-stage store data (DataBusB).
- `cpu_rdata` out 32: registered read data for the CPU.
- `cpu_stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB.
- `dbg_valid` in 1: debug request; held until `dbg_ready`.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in 32: debug address.
- `dbg_wdata` in 32: debug write data.
- `dbg_rdata` out 32: registered debug read data.
- `dbg_ready` out 1: one-cycle completion pulse.
- `bus_rd` out 1: read strobe to the slave.
- `bus_wr` out 1: write strobe to the slave.
- `bus_addr` out 32: slave address.
- `bus_wdata` out 32: slave write data.
- `bus_rdata` in 32: slave read data; valid when `bus_ready` = 1.
- `bus_ready` in 1: slave completion.
- `bus_err` out 1: one-cycle timeout pulse.

## Operation
- States: IDLE, CPU_XFER, CPU_DONE, DBG_XFER, DBG_DONE.
- **IDLE arbitration**
  - The CPU has a request when `cpu_rd | cpu_wr`. The CPU wins when it has a request, unless `dbg_valid` is high and `wait_cnt == MAX_WAIT`; in that case the debug port wins.
  - If only `dbg_valid` is high, the debug port wins.
  - The winner's command (rd/wr, addr, wdata) is latched. The FSM moves to CPU_XFER or DBG_XFER.
  - If `cpu_rd` and `cpu_wr` are both high, the access is treated as a write.
- **XFER states**
  - `bus_rd`, `bus_wr`, `bus_addr` and `bus_wdata` are driven from the latched command and held constant.
  - On `bus_ready` = 1: read data is captured into `cpu_rdata` or `dbg_rdata`, the strobes go low on the next edge, and the FSM moves to the matching DONE state.
- **CPU_DONE**: `cpu_stall` = 0 for exactly this cycle, so the pipeline advances. No arbitration takes place. The next state is IDLE.
- **DBG_DONE**: `dbg_ready` = 1 for exactly this cycle. `dbg_valid` may still be high here; this does not start a new transfer. The next state is IDLE.
- **`cpu_stall`** = `(cpu_rd | cpu_wr) & (state != CPU_DONE)`. It is combinational from the request inputs and is forced to 0 while `reset` = 0. A debug transfer in progress also stalls a requesting CPU.
- **`wait_cnt`**: increments in every cycle where `dbg_valid` = 1 and the FSM is not in DBG_XFER/DBG_DONE. It saturates at `MAX_WAIT` and clears when a debug grant is issued. Its width is `$clog2(MAX_WAIT+1)`.
- `cpu_rdata` and `dbg_rdata` hold their last value until the next read completion on the same port. Writes do not change them.

## Timing
- **Reset** (`reset` = 0 at a rising edge):
  - State goes to IDLE.
  - All strobes, `dbg_ready`, `bus_err`, `wait_cnt`, `cpu_rdata`, `dbg_rdata`, `bus_addr` and `bus_wdata` go to 0.
  - An in-flight transfer is dropped without any completion pulse.
- **CPU access latency**
  - Request seen in IDLE at cycle 0. Strobe high in cycles 1 through k, where k is the cycle with `bus_ready`.
  - CPU_DONE at k+1. Minimum stall is 2 cycles.
- **Debug access**: minimum 2 cycles from grant to `dbg_ready`.
- **Back-to-back accesses**: consecutive transfers are separated by at least one IDLE cycle.
- **`bus_ready` outside an XFER state**: ignored.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in each XFER state.
  - If `bus_ready` has not arrived after `TIMEOUT` strobe cycles, the strobes drop and `bus_err` pulses for one cycle.
  - Read data is captured as 32'h00000000, and the FSM proceeds to the DONE state as normal.
- Not defined: XFER states wait for `bus_ready` indefinitely, and `bus_err` is tied to 0.

## Test plan
- **CPU read, slave ready at once**: `cpu_rd` = 1, addr 0x00000010, `bus_rdata` 0x12345678 with `bus_ready` in cycle 1 -> `bus_rd` high for 1 cycle, `cpu_stall` high for 2 cycles, `cpu_rdata` = 0x12345678 at CPU_DONE.
- **Simultaneous requests**: `cpu_wr` and `dbg_valid` rise together, `wait_cnt` = 0 -> CPU granted first; debug is granted in the IDLE after CPU_DONE; `dbg_ready` pulses once.
- **Debug starvation**: `dbg_valid` held high while the CPU issues a request every IDLE cycle, `MAX_WAIT` = 8 -> the debug port wins the first IDLE arbitration after `wait_cnt` reaches 8, and `cpu_stall` stays high through DBG_XFER/DBG_DONE.
- **Wait states**: CPU read with `bus_ready` delayed 5 cycles -> `bus_addr` stable for 5 cycles, `cpu_stall` high for 6 cycles total, data captured only at `bus_ready`.
- **Reset mid-transfer**: `reset` = 0 during DBG_XFER -> next edge IDLE, strobes 0, no `dbg_ready`; after release the held `dbg_valid` is re-arbitrated and completes.
- **Timeout** (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 64): `bus_ready` never asserted -> strobes drop after 64 strobe cycles, `bus_err` pulses once, `cpu_rdata` = 0, `cpu_stall` falls in the following CPU_DONE cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the shared data-memory/peripheral bus to either the
// pipeline MEM stage (CPU) or the UART debug/loader port, one transfer at a time.
// The CPU has priority, but a debug request that keeps losing is forced through
// once it has waited MAX_WAIT cycles.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort transfers whose slave
// does not answer within TIMEOUT strobe cycles (bus_err pulses, read data = 0).
//
// Handshakes:
//   CPU   - cpu_rd/cpu_wr are a level request; the pipeline holds them while
//           cpu_stall = 1 and advances in the single cycle where cpu_stall = 0.
//   debug - dbg_valid is held with a stable command until the one-cycle
//           dbg_ready pulse; dbg_valid still high during that pulse is not a
//           new request.
//   slave - bus_rd/bus_wr and bus_addr/bus_wdata stay constant until the slave
//           answers with bus_ready = 1; bus_rdata is sampled in that cycle.
module mem_bus_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    // MEM-stage master
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    // debug/loader master
    input  logic        dbg_valid,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ready,
    // slave side
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err,
    // current FSM state, for observation only
    output logic [2:0]  arb_state
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_XFER = 3'd1,
        CPU_DONE = 3'd2,
        DBG_XFER = 3'd3,
        DBG_DONE = 3'd4
    } state_t;

    state_t          state;
    logic [WW-1:0]   wait_cnt;
    logic [TW-1:0]   xfer_cnt;
    logic            cpu_req;
    logic            wait_full;
    logic            dbg_win;
    logic            dbg_busy;
    logic            in_xfer;
    logic            timed_out;
    logic            xfer_end;

    assign cpu_req   = cpu_rd | cpu_wr;
    assign wait_full = (wait_cnt == WW'(MAX_WAIT));
    // Debug wins when the CPU is quiet, or when it has been starved long enough.
    assign dbg_win   = dbg_valid & (~cpu_req | wait_full);
    assign dbg_busy  = (state == DBG_XFER) || (state == DBG_DONE);
    assign in_xfer   = (state == CPU_XFER) || (state == DBG_XFER);
    // Without the timeout feature this is constant 0 and the counter is pruned.
    assign timed_out = TIMEOUT_EN && (xfer_cnt == TW'(TIMEOUT - 1));
    assign xfer_end  = bus_ready | timed_out;

    // The pipeline only runs free in CPU_DONE; held low while in reset.
    assign cpu_stall = reset & cpu_req & (state != CPU_DONE);
    assign arb_state = state;

    // Count strobe cycles spent waiting on the slave in an XFER state.
    always_ff @(posedge clk) begin
        if (!reset || !in_xfer || bus_ready) begin
            xfer_cnt <= '0;
        end else if (!timed_out) begin
            xfer_cnt <= xfer_cnt + TW'(1);
        end
    end

    // Arbitration, command latching, completion and the starvation counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            dbg_ready <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            dbg_ready <= 1'b0;
            bus_err   <= 1'b0;

            if (state == IDLE && dbg_win) begin
                wait_cnt <= '0;
            end else if (dbg_valid && !dbg_busy && !wait_full) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            case (state)
                IDLE: begin
                    if (dbg_win) begin
                        bus_rd    <= ~dbg_we;
                        bus_wr    <= dbg_we;
                        bus_addr  <= dbg_addr;
                        bus_wdata <= dbg_wdata;
                        state     <= DBG_XFER;
                    end else if (cpu_req) begin
                        // Both strobes requested: the write takes precedence.
                        bus_rd    <= cpu_rd & ~cpu_wr;
                        bus_wr    <= cpu_wr;
                        bus_addr  <= cpu_addr;
                        bus_wdata <= cpu_wdata;
                        state     <= CPU_XFER;
                    end
                end
                CPU_XFER: begin
                    if (xfer_end) begin
                        if (bus_rd) cpu_rdata <= bus_ready ? bus_rdata : 32'h0;
                        bus_err <= ~bus_ready;
                        bus_rd  <= 1'b0;
                        bus_wr  <= 1'b0;
                        state   <= CPU_DONE;
                    end
                end
                DBG_XFER: begin
                    if (xfer_end) begin
                        if (bus_rd) dbg_rdata <= bus_ready ? bus_rdata : 32'h0;
                        bus_err   <= ~bus_ready;
                        bus_rd    <= 1'b0;
                        bus_wr    <= 1'b0;
                        dbg_ready <= 1'b1;
                        state     <= DBG_DONE;
                    end
                end
                CPU_DONE: state <= IDLE;
                DBG_DONE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level reference of the arbiter.
module tb_mem_bus_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int TIMEOUT  = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ready;
    logic        bus_rd, bus_wr;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ready, bus_err;
    logic [2:0]  arb_state;

    mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err),
        .arb_state(arb_state)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // owner: 0 none, 1 cpu, 2 debug; phase: 0 arbitrating, 1 on the bus, 2 done
    int          m_owner = 0;
    int          m_phase = 0;
    int          m_wait  = 0;
    int          m_cnt   = 0;
    logic        m_rd = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_crd = '0, m_drd = '0;
    logic [31:0] exp_q[$];

    bit hold_cpu = 1'b0;
    int cyc, n_rd_hi, n_stall, n_ready, n_err, first_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic complete(input logic [31:0] d);
        if (m_rd) begin
            if (m_owner == 1) m_crd = d;
            else              m_drd = d;
        end
        if (m_owner == 2) exp_q.push_back(m_drd);
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_phase = 2;
    endtask

    // Advance the reference by one clock using the inputs seen at this edge.
    task automatic model_step();
        bit cpu_req, was_dbg, grant_dbg;
        if (!reset) begin
            m_owner = 0; m_phase = 0; m_wait = 0; m_cnt = 0;
            m_rd = 0; m_wr = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_crd = 0; m_drd = 0;
            return;
        end
        cpu_req   = cpu_rd | cpu_wr;
        was_dbg   = (m_owner == 2) && (m_phase != 0);
        grant_dbg = 1'b0;
        m_err     = 1'b0;
        if (m_phase == 0) begin
            if (dbg_valid && (!cpu_req || m_wait == MAX_WAIT)) begin
                grant_dbg = 1'b1;
                m_owner = 2; m_rd = !dbg_we; m_wr = dbg_we;
                m_addr = dbg_addr; m_wdata = dbg_wdata;
                m_phase = 1; m_cnt = 0;
            end else if (cpu_req) begin
                m_owner = 1; m_wr = cpu_wr; m_rd = !cpu_wr;
                m_addr = cpu_addr; m_wdata = cpu_wdata;
                m_phase = 1; m_cnt = 0;
            end
        end else if (m_phase == 1) begin
            if (bus_ready) begin
                complete(bus_rdata);
            end else begin
                m_cnt++;
`ifdef MEM_ARB_TIMEOUT_EN
                if (m_cnt == TIMEOUT) begin
                    complete(32'h0);
                    m_err = 1'b1;
                end
`endif
            end
        end else begin
            m_phase = 0;
            m_owner = 0;
        end
        if (grant_dbg) m_wait = 0;
        else if (dbg_valid && !was_dbg && m_wait < MAX_WAIT) m_wait++;
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic clr_counts();
        cyc = 0; n_rd_hi = 0; n_stall = 0; n_ready = 0; n_err = 0; first_ready = -1;
    endtask

    // Compare every output against the reference mid-cycle.
    task automatic sample();
        logic exp_stall;
        @(negedge clk);
        exp_stall = reset & (cpu_rd | cpu_wr) & !(m_owner == 1 && m_phase == 2);
        chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        chk("bus_rd",    32'(bus_rd),    32'(m_rd));
        chk("bus_wr",    32'(bus_wr),    32'(m_wr));
        chk("bus_addr",  bus_addr,       m_addr);
        chk("bus_wdata", bus_wdata,      m_wdata);
        chk("cpu_rdata", cpu_rdata,      m_crd);
        chk("dbg_rdata", dbg_rdata,      m_drd);
        chk("dbg_ready", 32'(dbg_ready), 32'(m_owner == 2 && m_phase == 2));
        chk("bus_err",   32'(bus_err),   32'(m_err));
        if (dbg_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_spurious_ready", 32'd1, 32'd0);
            else                   chk("sb_dbg_rdata", dbg_rdata, exp_q.pop_front());
        end
        n_rd_hi += int'(bus_rd === 1'b1);
        n_stall += int'(cpu_stall === 1'b1);
        n_ready += int'(dbg_ready === 1'b1);
        n_err   += int'(bus_err === 1'b1);
        if (dbg_ready === 1'b1 && first_ready < 0) first_ready = cyc;
    endtask

    // Clock edge: update the reference, then release requests that completed.
    task automatic tick();
        bit cpu_done_now, dbg_done_now;
        cpu_done_now = (m_owner == 1 && m_phase == 2);
        dbg_done_now = (m_owner == 2 && m_phase == 2);
        @(posedge clk);
        model_step();
        #1;
        if (cpu_done_now && !hold_cpu) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
        if (dbg_done_now) dbg_valid = 1'b0;
        cyc++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        bus_rdata = 0; bus_ready = 0;
        clr_counts();
        // reset state
        repeat (3) begin sample(); tick(); end
        reset = 1'b1;
        repeat (2) begin sample(); tick(); end

        // CPU read, slave ready at once
        clr_counts();
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0010;
        for (int i = 0; i < 4; i++) begin
            bus_ready = (i == 1);
            bus_rdata = (i == 1) ? 32'h1234_5678 : 32'hFFFF_0000;
            sample();
            if (i == 2) chk("t1_rdata_at_done", cpu_rdata, 32'h1234_5678);
            tick();
        end
        chk("t1_rd_cycles", n_rd_hi, 1);
        chk("t1_stall_cycles", n_stall, 2);

        // simultaneous CPU write and debug read
        clr_counts();
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hAAAA_5555;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; dbg_wdata = 32'h0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (i == 1) chk("t2_cpu_first", 32'(bus_wr), 32'd1);
            tick();
        end
        chk("t2_ready_pulses", n_ready, 1);
        chk("t2_ready_cycle", first_ready, 5);
        chk("t2_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);

        // debug starvation under continuous CPU reads
        clr_counts();
        hold_cpu = 1'b1;
        bus_rdata = 32'h0BEE_F000;
        cpu_rd = 1'b1; cpu_addr = 32'h100;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 18; i++) begin
            if (i == 12) hold_cpu = 1'b0;
            sample();
            if (i == 10 || i == 11) chk("t3_stall_during_dbg", 32'(cpu_stall), 32'd1);
            if (i == 10) chk("t3_dbg_wdata", bus_wdata, 32'hDEAD_BEEF);
            tick();
        end
        chk("t3_ready_cycle", first_ready, 11);
        chk("t3_ready_pulses", n_ready, 1);

        // CPU read with five-cycle slave latency
        clr_counts();
        cpu_rd = 1'b1; cpu_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            bus_ready = (i == 5);
            bus_rdata = (i == 5) ? 32'h0BAD_F00D : 32'h1111_1111 * i;
            sample();
            tick();
        end
        chk("t4_rd_cycles", n_rd_hi, 5);
        chk("t4_stall_cycles", n_stall, 6);
        chk("t4_rdata", cpu_rdata, 32'h0BAD_F00D);

        // reset during a debug transfer
        clr_counts();
        bus_rdata = 32'h55AA_55AA;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h400;
        for (int i = 0; i < 7; i++) begin
            reset = (i != 2);
            bus_ready = (i >= 3);
            sample();
            if (i == 3) chk("t5_strobe_after_reset", 32'(bus_rd), 32'd0);
            tick();
        end
        chk("t5_ready_pulses", n_ready, 1);
        chk("t5_ready_cycle", first_ready, 5);
        chk("t5_dbg_rdata", dbg_rdata, 32'h55AA_55AA);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!cpu_rd && !cpu_wr && $urandom_range(0, 2) == 0) begin
                int op;
                op = $urandom_range(0, 2);
                cpu_rd = (op != 1); cpu_wr = (op != 0);
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (!dbg_valid && $urandom_range(0, 3) == 0) begin
                dbg_valid = 1'b1; dbg_we = $urandom_range(0, 1) == 1;
                dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            bus_ready = $urandom_range(0, 1) == 1;
            bus_rdata = $urandom;
            reset = $urandom_range(0, 199) != 0;
            sample();
            tick();
        end
        // drain outstanding requests
        reset = 1'b1; bus_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin sample(); tick(); end

`ifdef MEM_ARB_TIMEOUT_EN
        // slave never answers
        clr_counts();
        bus_ready = 1'b0; bus_rdata = 32'h7777_7777;
        cpu_rd = 1'b1; cpu_addr = 32'h500;
        for (int i = 0; i < 70; i++) begin sample(); tick(); end
        chk("t6_rd_cycles", n_rd_hi, TIMEOUT);
        chk("t6_err_pulses", n_err, 1);
        chk("t6_rdata", cpu_rdata, 32'h0);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
